// File: rtl/vend_pkg.sv
// Shared types and coin helpers for the vending credit controller.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_V1   = 2'b01;
  localparam logic [1:0] COIN_V2   = 2'b10;
  localparam logic [1:0] COIN_V3   = 2'b11;

  function automatic int coin_value(input logic [1:0] code, input int v1, input int v2,
                                    input int v3);
    case (code)
      COIN_V1: return v1;
      COIN_V2: return v2;
      COIN_V3: return v3;
      default: return 0;
    endcase
  endfunction

  // Greedy pick: largest denomination not exceeding the amount still owed.
  function automatic logic [1:0] largest_coin(input int amount, input int v1, input int v2,
                                              input int v3);
    if (amount >= v3)      return COIN_V3;
    else if (amount >= v2) return COIN_V2;
    else if (amount >= v1) return COIN_V1;
    else                   return COIN_NONE;
  endfunction

endpackage

// File: rtl/vend_change_disp.sv
// Greedy change dispenser: pays out a loaded amount one coin at a time over valid/ready.
module vend_change_disp
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8,
  parameter int VAL1     = 5,
  parameter int VAL2     = 10,
  parameter int VAL3     = 25
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_load,
  input  logic [CREDIT_W-1:0] i_amount,
  input  logic                i_change_ready,
  output logic                o_done,
  output logic                o_change_valid,
  output logic [1:0]          o_change_coin
);

  logic [CREDIT_W-1:0] r_remaining;
  logic                r_valid;
  logic [1:0]          r_coin;

  logic                w_fire;
  logic [CREDIT_W-1:0] w_paid;
  logic [CREDIT_W-1:0] w_left;

  assign w_fire = r_valid && i_change_ready;
  assign w_paid = CREDIT_W'(coin_value(r_coin, VAL1, VAL2, VAL3));
  assign w_left = r_remaining - w_paid;
  assign o_done = w_fire && (w_left == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_remaining <= '0;
      r_valid     <= 1'b0;
      r_coin      <= COIN_NONE;
    end else if (i_load) begin
      r_remaining <= i_amount;
      r_valid     <= (i_amount != '0);
      r_coin      <= largest_coin(32'(i_amount), VAL1, VAL2, VAL3);
    end else if (w_fire) begin
      r_remaining <= w_left;
      r_valid     <= (w_left != '0);
      r_coin      <= largest_coin(32'(w_left), VAL1, VAL2, VAL3);
    end
  end

  assign o_change_valid = r_valid;
  assign o_change_coin  = r_coin;

  // The hopper may sample the coin on any cycle it is offered, so it must not move.
  assert property (@(posedge clk) disable iff (!reset_n)
                   (o_change_valid && !i_change_ready) |=> $stable(o_change_coin));

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending controller: credit accumulation, vend pulse, refund/timeout and change payout.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_W    = 8,
  parameter int VAL1        = 5,
  parameter int VAL2        = 10,
  parameter int VAL3        = 25,
  parameter int PRICE       = 15,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic                vend,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int CREDIT_MAX = (1 << CREDIT_W) - 1;

  if ((VAL1 <= 0) || ((VAL2 % VAL1) != 0) || ((VAL3 % VAL1) != 0) ||
      ((PRICE % VAL1) != 0) || (PRICE <= 0) || (PRICE > CREDIT_MAX)) begin : g_bad_cfg
    $error("vend_credit_ctrl: VAL1 must divide VAL2, VAL3 and PRICE; PRICE must fit CREDIT_W");
  end

  state_t              r_state;
  state_t              w_state_next;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_next;
  logic                r_accept;
  logic                r_reject;
  logic                r_vend;
  logic                r_busy;
  logic                w_accept;
  logic                w_reject;
  logic                w_vend;
  logic                w_load;
  logic [CREDIT_W-1:0] w_load_amount;
  logic                w_done;
  logic                w_coin_event;
  logic                w_timeout;
  logic                w_handshake;
  int                  w_sum;
  logic [CREDIT_W-1:0] w_remainder;
  logic [CREDIT_W-1:0] w_paid;

  assign w_coin_event = coin_valid && (coin != COIN_NONE);
  assign w_sum        = int'(r_credit) + coin_value(coin, VAL1, VAL2, VAL3);
  assign w_remainder  = r_credit - CREDIT_W'(PRICE);
  assign w_handshake  = change_valid && change_ready;
  assign w_paid       = CREDIT_W'(coin_value(change_coin, VAL1, VAL2, VAL3));

  // Counts idle COLLECT cycles; any coin event or leaving COLLECT restarts it.
  if (TIMEOUT_CYC > 0) begin : g_timeout
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] r_idle_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        r_idle_cnt <= '0;
      else if ((r_state != ST_COLLECT) || w_coin_event)
        r_idle_cnt <= '0;
      else if (!w_timeout)
        r_idle_cnt <= r_idle_cnt + 1'b1;
    end

    assign w_timeout = (r_state == ST_COLLECT) && !w_coin_event &&
                       (r_idle_cnt == TW'(TIMEOUT_CYC - 1));
  end else begin : g_no_timeout
    assign w_timeout = 1'b0;
  end

  always_comb begin
    w_state_next  = r_state;
    w_credit_next = r_credit;
    w_accept      = 1'b0;
    w_reject      = 1'b0;
    w_vend        = 1'b0;
    w_load        = 1'b0;
    w_load_amount = r_credit;
    case (r_state)
      ST_IDLE: begin
        if (w_coin_event) begin
          if (w_sum > CREDIT_MAX) begin
            w_reject = 1'b1;
          end else begin
            w_accept      = 1'b1;
            w_credit_next = CREDIT_W'(w_sum);
            w_state_next  = (w_sum >= PRICE) ? ST_VEND : ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        if (cancel || w_timeout) begin
          // Refund wins over a coin arriving in the same cycle.
          w_reject      = w_coin_event;
          w_load        = 1'b1;
          w_load_amount = r_credit;
          w_state_next  = ST_CHANGE;
        end else if (w_coin_event) begin
          if (w_sum > CREDIT_MAX) begin
            w_reject = 1'b1;
          end else begin
            w_accept      = 1'b1;
            w_credit_next = CREDIT_W'(w_sum);
            if (w_sum >= PRICE) w_state_next = ST_VEND;
          end
        end
      end
      ST_VEND: begin
        w_vend        = 1'b1;
        w_reject      = w_coin_event;
        w_credit_next = w_remainder;
        if (w_remainder != '0) begin
          w_load        = 1'b1;
          w_load_amount = w_remainder;
          w_state_next  = ST_CHANGE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        w_reject = w_coin_event;
        if (w_handshake) w_credit_next = r_credit - w_paid;
        if (w_done) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_credit <= '0;
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      r_vend   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_credit <= w_credit_next;
      r_accept <= w_accept;
      r_reject <= w_reject;
      r_vend   <= w_vend;
      r_busy   <= (w_state_next != ST_IDLE);
    end
  end

  vend_change_disp #(
    .CREDIT_W(CREDIT_W),
    .VAL1    (VAL1),
    .VAL2    (VAL2),
    .VAL3    (VAL3)
  ) u_change_disp (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_load        (w_load),
    .i_amount      (w_load_amount),
    .i_change_ready(change_ready),
    .o_done        (w_done),
    .o_change_valid(change_valid),
    .o_change_coin (change_coin)
  );

  assign coin_accept = r_accept;
  assign coin_reject = r_reject;
  assign vend        = r_vend;
  assign credit      = r_credit;
  assign busy        = r_busy;

endmodule
